// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-ROM read port, decode-side valid/ready
// head port, redirect request and buffer occupancy.
// master = fetch unit, slave = ROM/decode/redirect source.
interface instr_fetch_unit_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   imem_addr;
    logic [31:0]   imem_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_exc;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] fifo_count;

    modport master (
        output imem_addr,
        input  imem_data,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output out_exc,
        input  redirect_valid,
        input  redirect_pc,
        output fifo_count
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  out_exc,
        output redirect_valid,
        output redirect_pc,
        input  fifo_count
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational ROM, buffers
// {pc, instr, exc} entries in a small FIFO for decode, flushes on redirect
// and turns out-of-range / misaligned fetches into AdEL entries.
// Optional macro IFU_PERF_CNT_EN adds fetch and stall performance counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] MEM_BASE   = 32'h0000_3000,
    parameter logic [31:0] MEM_LIMIT  = 32'h0000_4FFF,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_unit_if.master   bus
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0]   LAST_WORD = MEM_LIMIT - 32'd3;
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [CW-1:0] CNT_ONE   = 1;
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic {ST_RUN, ST_FAULT} state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic [31:0]   mem_pc    [FIFO_DEPTH];
    logic [31:0]   mem_instr [FIFO_DEPTH];
    logic          mem_exc   [FIFO_DEPTH];

    logic          full, pop, push, pc_legal;

    assign full     = (count == CNT_FULL);
    assign pop      = bus.out_valid && bus.out_ready;
    assign pc_legal = (pc[1:0] == 2'b00) && (pc >= MEM_BASE) && (pc <= LAST_WORD);

    // Head presentation: zeros while empty so the storage itself needs no reset
    always_comb begin
        bus.out_valid  = (count != '0);
        bus.out_pc     = bus.out_valid ? mem_pc[rd_ptr]    : 32'h0;
        bus.out_instr  = bus.out_valid ? mem_instr[rd_ptr] : 32'h0;
        bus.out_exc    = bus.out_valid ? mem_exc[rd_ptr]   : 1'b0;
        bus.imem_addr  = pc;
        bus.fifo_count = count;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    // FSM next state: a redirect always returns to RUN, an illegal push faults
    always_comb begin
        state_nxt = state;
        if (bus.redirect_valid)
            state_nxt = ST_RUN;
        else if (push && !pc_legal)
            state_nxt = ST_FAULT;
    end

    // FSM outputs: push only in RUN, never in a redirect cycle
    always_comb begin
        push = 1'b0;
        if (state == ST_RUN && !bus.redirect_valid)
            push = !full || pop;
    end

    // PC, pointers and occupancy; redirect flushes and overrides push/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect_valid) begin
            pc     <= bus.redirect_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push && pc_legal) pc <= pc + 32'd4;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; an address-error entry carries a zero instruction
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= pc;
            mem_instr[wr_ptr] <= pc_legal ? bus.imem_data : 32'h0;
            mem_exc[wr_ptr]   <= !pc_legal;
        end
    end

`ifdef IFU_PERF_CNT_EN
    // Performance counters: cleared only by reset, wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push && pc_legal)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (state == ST_RUN && full && !pop)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
// The ROM model returns addr ^ 32'hDEAD_0000 so every expected instruction
// is derived from its PC.
module tb_instr_fetch_unit;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    instr_fetch_unit_if #(.FIFO_DEPTH(4)) bus ();

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_3000),
        .MEM_BASE   (32'h0000_3000),
        .MEM_LIMIT  (32'h0000_4FFF),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    assign bus.imem_data = bus.imem_addr ^ 32'hDEAD_0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] a);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = a;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'h0);
        chk({tag, "_pc"},    bus.out_pc,          32'h0);
        chk({tag, "_instr"}, bus.out_instr,       32'h0);
        chk({tag, "_exc"},   32'(bus.out_exc),    32'h0);
        chk({tag, "_count"}, 32'(bus.fifo_count), 32'h0);
        chk({tag, "_addr"},  bus.imem_addr,       32'h0000_3000);
    endtask

    initial begin
        reset              = 1'b1;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // Reset state and streaming fetch with ready held high
        do_reset();
        chk_reset_state("rst0");
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("stream_valid", 32'(bus.out_valid), 32'h1);
            chk("stream_pc",    bus.out_pc,         32'h3000 + 32'(4 * k));
            chk("stream_instr", bus.out_instr,      rom(32'h3000 + 32'(4 * k)));
            chk("stream_exc",   32'(bus.out_exc),   32'h0);
        end

        // Back-pressure: fill to 4, PC parks at 0x3010, drain without gap
        do_reset();
        bus.out_ready = 1'b0;
        repeat (10) step();
        chk("full_count", 32'(bus.fifo_count), 32'h4);
        chk("full_addr",  bus.imem_addr,       32'h3010);
        chk("full_head",  bus.out_pc,          32'h3000);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("drain_pc",    bus.out_pc,          32'h3000 + 32'(4 * k));
            chk("drain_count", 32'(bus.fifo_count), 32'h4);
            step();
        end

        // Redirect with 3 buffered entries while popping
        do_reset();
        bus.out_ready = 1'b0;
        repeat (3) step();
        chk("pre_redir_count", 32'(bus.fifo_count), 32'h3);
        bus.out_ready = 1'b1;
        redirect(32'h3400);
        chk("redir_count", 32'(bus.fifo_count), 32'h0);
        chk("redir_valid", 32'(bus.out_valid),  32'h0);
        chk("redir_addr",  bus.imem_addr,       32'h3400);
        step();
        chk("redir_first_valid", 32'(bus.out_valid), 32'h1);
        chk("redir_first_pc",    bus.out_pc,         32'h3400);
        step();
        chk("redir_second_pc",   bus.out_pc,         32'h3404);

        // Run off the end of memory: 0x4FFC legal, 0x5000 faults
        redirect(32'h4FF4);
        step();
        chk("end_pc0", bus.out_pc, 32'h4FF4);
        step();
        chk("end_pc1", bus.out_pc, 32'h4FF8);
        step();
        chk("last_pc",    bus.out_pc,        32'h4FFC);
        chk("last_exc",   32'(bus.out_exc),  32'h0);
        chk("last_instr", bus.out_instr,     rom(32'h4FFC));
        step();
        chk("over_valid", 32'(bus.out_valid), 32'h1);
        chk("over_pc",    bus.out_pc,         32'h5000);
        chk("over_exc",   32'(bus.out_exc),   32'h1);
        chk("over_instr", bus.out_instr,      32'h0);
        step();
        chk("fault_valid", 32'(bus.out_valid), 32'h0);
        chk("fault_addr",  bus.imem_addr,      32'h5000);
        repeat (3) step();
        chk("fault_hold_valid", 32'(bus.out_valid),  32'h0);
        chk("fault_hold_count", 32'(bus.fifo_count), 32'h0);
        redirect(32'h3000);
        step();
        chk("resume_pc",  bus.out_pc,       32'h3000);
        chk("resume_exc", 32'(bus.out_exc), 32'h0);

        // Misaligned redirect faults; reset leaves FAULT
        redirect(32'h3002);
        step();
        chk("mis_pc",    bus.out_pc,       32'h3002);
        chk("mis_exc",   32'(bus.out_exc), 32'h1);
        chk("mis_instr", bus.out_instr,    32'h0);
        step();
        chk("mis_drained", 32'(bus.out_valid), 32'h0);
        step();
        chk("mis_hold_valid", 32'(bus.out_valid), 32'h0);
        chk("mis_hold_addr",  bus.imem_addr,      32'h3002);
        do_reset();
        chk_reset_state("rst1");
        step();
        chk("post_rst_valid", 32'(bus.out_valid), 32'h1);
        chk("post_rst_pc",    bus.out_pc,         32'h3000);

        // Back-to-back redirects: the last one wins
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3100;
        step();
        bus.redirect_pc    = 32'h3200;
        step();
        bus.redirect_valid = 1'b0;
        chk("b2b_addr",  bus.imem_addr,       32'h3200);
        chk("b2b_count", 32'(bus.fifo_count), 32'h0);
        step();
        chk("b2b_pc",    bus.out_pc,          32'h3200);

        // Below MEM_BASE is an address error
        redirect(32'h2FFC);
        step();
        chk("low_pc",  bus.out_pc,       32'h2FFC);
        chk("low_exc", 32'(bus.out_exc), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
